// File: rtl/regfile_bus_master.sv
// Request/response front-end for the 8-bit register file: turns valid/ready
// requests into register-file bus cycles and arbitrates the shared data bus.
module regfile_bus_master #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 64
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ADDR_WIDTH-1:0] rf_address,
   output logic                  rf_en_write,
   inout  wire  [DATA_WIDTH-1:0] rf_data
);

   typedef enum logic [2:0] {IDLE, WRITE, READ_ADDR, READ_CAP, RESP} state_t;

   localparam logic [ADDR_WIDTH:0] DEPTH_LIMIT = (ADDR_WIDTH+1)'(DEPTH);

   state_t                state, state_next;
   logic                  accept, in_range;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_next;
   logic [ADDR_WIDTH-1:0] addr_next;
   logic                  en_next, rsp_valid_next, rsp_err_next;
   logic [DATA_WIDTH-1:0] rsp_rdata_next;

   assign in_range = ({1'b0, req_addr} < DEPTH_LIMIT);
   assign req_ready = reset_n && ((state == IDLE) || (state == RESP && rsp_ready));
   assign accept = req_valid && req_ready;

   // The write enable flop doubles as the data-bus drive enable, so ownership
   // flips at the same edge that en_write changes and no turnaround is needed.
   assign rf_data = rf_en_write ? wdata_q : {DATA_WIDTH{1'bz}};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, RESP: begin
            if (accept) begin
               if (!in_range) begin
                  state_next = RESP;
               end else if (req_write) begin
                  state_next = WRITE;
               end else begin
                  state_next = READ_ADDR;
               end
            end else if (state == RESP && rsp_ready) begin
               state_next = IDLE;
            end
         end
         WRITE:     state_next = RESP;
         READ_ADDR: state_next = READ_CAP;
         READ_CAP:  state_next = RESP;
         default:   state_next = IDLE;
      endcase
   end

   always_comb begin
      en_next        = (state_next == WRITE);
      addr_next      = rf_address;
      wdata_next     = wdata_q;
      rsp_valid_next = rsp_valid;
      rsp_err_next   = rsp_err;
      rsp_rdata_next = rsp_rdata;
      if (accept) begin
         // Out-of-range requests answer straight away and never touch the bus.
         rsp_valid_next = !in_range;
         rsp_err_next   = !in_range;
         rsp_rdata_next = '0;
         if (in_range) begin
            addr_next = req_addr;
            if (req_write) begin
               wdata_next = req_wdata;
            end
         end
      end else begin
         case (state)
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid_next = 1'b0;
               end
            end
            WRITE: begin
               rsp_valid_next = 1'b1;
               rsp_err_next   = 1'b0;
               rsp_rdata_next = '0;
            end
            READ_CAP: begin
               rsp_valid_next = 1'b1;
               rsp_err_next   = 1'b0;
               rsp_rdata_next = rf_data;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rf_en_write <= 1'b0;
         rf_address  <= '0;
         wdata_q     <= '0;
         rsp_valid   <= 1'b0;
         rsp_err     <= 1'b0;
         rsp_rdata   <= '0;
      end else begin
         rf_en_write <= en_next;
         rf_address  <= addr_next;
         wdata_q     <= wdata_next;
         rsp_valid   <= rsp_valid_next;
         rsp_err     <= rsp_err_next;
         rsp_rdata   <= rsp_rdata_next;
      end
   end

endmodule

// File: tb/tb_regfile_bus_master.sv
// Bench for regfile_bus_master with a behavioural registered-read register
// file on the shared bus and a response scoreboard.
module tb_regfile_bus_master;

   typedef struct {
      logic       wr;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
      logic       exp_err;
      int         exp_lat;
      int         exp_gap;
   } vec_t;

   typedef struct {
      logic [7:0] rdata;
      logic       err;
      int         lat;
      int         acc_cyc;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_write = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_valid;
   logic       rsp_ready = 1'b1;
   logic [7:0] rsp_rdata;
   logic       rsp_err;
   logic [7:0] rf_address;
   logic       rf_en_write;
   // Pulled high so a released bus with the register file silenced reads 0xFF.
   tri1  [7:0] rf_data;

   logic [7:0] mem [0:255] = '{default: 8'h00};
   logic [7:0] rd_q = 8'h00;
   logic       model_oe = 1'b0;

   exp_t       sb[$];
   vec_t       tbl[$];
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;
   int         en_pulses = 0;
   logic       prev_en = 1'b0;
   logic [7:0] exp_bus_addr = 8'h00;
   logic [7:0] exp_bus_data = 8'h00;
   bit         resp_seen = 1'b0;
   int         last_acc = -100;

   regfile_bus_master #(.DATA_WIDTH(8), .ADDR_WIDTH(8), .DEPTH(64)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_rdata   (rsp_rdata),
      .rsp_err     (rsp_err),
      .rf_address  (rf_address),
      .rf_en_write (rf_en_write),
      .rf_data     (rf_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // Register file: commits on en_write, registers its read every edge, and
   // drives the bus whenever it is not being written.
   always @(posedge clock) begin
      if (rf_en_write) mem[rf_address] <= rf_data;
      rd_q <= mem[rf_address];
   end
   assign rf_data = (model_oe && !rf_en_write) ? rd_q : 8'hzz;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   always @(negedge clock) begin
      if (reset_n) begin
         if (model_oe) check_output("rf_data_known", 32'($isunknown(rf_data)), 32'd0);
         if (rf_en_write) begin
            check_output("wr_address", 32'(rf_address), 32'(exp_bus_addr));
            check_output("wr_data", 32'(rf_data), 32'(exp_bus_data));
            check_output("wr_pulse_width", 32'(prev_en), 32'd0);
            if (!prev_en) en_pulses++;
         end
         if (rsp_valid) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("[TB] FAIL unexpected_rsp: got rsp_valid 1 expected 0 at cycle %0d", cyc);
            end else begin
               if (!resp_seen) begin
                  check_output("rsp_latency", 32'(cyc - sb[0].acc_cyc), 32'(sb[0].lat));
                  resp_seen = 1'b1;
               end
               check_output("rsp_rdata", 32'(rsp_rdata), 32'(sb[0].rdata));
               check_output("rsp_err", 32'(rsp_err), 32'(sb[0].err));
               if (rsp_ready) begin
                  void'(sb.pop_front());
                  resp_seen = 1'b0;
               end
            end
         end
      end
      prev_en = rf_en_write;
   end

   // Called shortly after a rising edge; returns just after the acceptance edge.
   task automatic apply_stimulus(input vec_t v);
      bit accepted = 1'b0;
      req_valid = 1'b1;
      req_write = v.wr;
      req_addr  = v.addr;
      req_wdata = v.wdata;
      for (int i = 0; i < 20 && !accepted; i++) begin
         @(negedge clock);
         if (req_ready) begin
            accepted = 1'b1;
            sb.push_back('{rdata: v.exp_rdata, err: v.exp_err, lat: v.exp_lat, acc_cyc: cyc + 1});
            if (v.wr) begin
               exp_bus_addr = v.addr;
               exp_bus_data = v.wdata;
            end
            if (v.exp_gap > 0) check_output("accept_gap", 32'(cyc + 1 - last_acc), 32'(v.exp_gap));
            last_acc = cyc + 1;
         end
      end
      if (!accepted) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL accept_timeout: got req_ready 0 expected 1 for addr %0h", v.addr);
      end
      @(posedge clock);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60 && sb.size() > 0; i++) @(negedge clock);
      if (sb.size() > 0) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
         sb.delete();
         resp_seen = 1'b0;
      end
      @(posedge clock);
      #1;
   endtask

   function automatic vec_t mk(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                               input logic [7:0] rdata, input logic err, input int lat, input int gap);
      vec_t v;
      v.wr = wr; v.addr = addr; v.wdata = wdata; v.exp_rdata = rdata;
      v.exp_err = err; v.exp_lat = lat; v.exp_gap = gap;
      return v;
   endfunction

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no finish expected finish within time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int pulses_before;
      int exp_pulses;

      #12;
      check_output("rst_req_ready", 32'(req_ready), 32'd0);
      check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
      check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
      check_output("rst_en_write", 32'(rf_en_write), 32'd0);
      check_output("rst_address", 32'(rf_address), 32'd0);
      check_output("rst_bus_released", 32'(rf_data), 32'hFF);
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      model_oe = 1'b1;

      // Basic traffic and out-of-range requests.
      tbl.push_back(mk(1'b1, 8'd0,   8'h11, 8'h00, 1'b0, 1, 0));
      tbl.push_back(mk(1'b1, 8'd3,   8'hA5, 8'h00, 1'b0, 1, 0));
      tbl.push_back(mk(1'b0, 8'd3,   8'h00, 8'hA5, 1'b0, 2, 0));
      tbl.push_back(mk(1'b0, 8'd64,  8'h00, 8'h00, 1'b1, 0, 0));
      tbl.push_back(mk(1'b1, 8'hFF,  8'h77, 8'h00, 1'b1, 0, 0));
      tbl.push_back(mk(1'b1, 8'd64,  8'h66, 8'h00, 1'b1, 0, 0));
      tbl.push_back(mk(1'b0, 8'd0,   8'h00, 8'h11, 1'b0, 2, 0));
      tbl.push_back(mk(1'b0, 8'd63,  8'h00, 8'h00, 1'b0, 2, 0));
      pulses_before = en_pulses;
      exp_pulses = 0;
      foreach (tbl[i]) begin
         if (tbl[i].wr && tbl[i].addr < 8'd64) exp_pulses++;
         apply_stimulus(tbl[i]);
      end
      wait_drain();
      check_output("table_wr_pulses", 32'(en_pulses - pulses_before), 32'(exp_pulses));

      // Streaming: writes every 2 cycles, reads every 3, rsp_ready held high.
      tbl.delete();
      for (int i = 0; i < 8; i++)
         tbl.push_back(mk(1'b1, 8'(i), 8'(i + 1), 8'h00, 1'b0, 1, (i == 0) ? 0 : 2));
      for (int i = 7; i >= 0; i--)
         tbl.push_back(mk(1'b0, 8'(i), 8'h00, 8'(i + 1), 1'b0, 2, (i == 7) ? 2 : 3));
      pulses_before = en_pulses;
      foreach (tbl[i]) apply_stimulus(tbl[i]);
      wait_drain();
      check_output("stream_wr_pulses", 32'(en_pulses - pulses_before), 32'd8);

      // Backpressure: response held while rsp_ready is low, no new acceptance.
      apply_stimulus(mk(1'b1, 8'd10, 8'h5A, 8'h00, 1'b0, 1, 0));
      wait_drain();
      rsp_ready = 1'b0;
      pulses_before = en_pulses;
      apply_stimulus(mk(1'b0, 8'd10, 8'h00, 8'h5A, 1'b0, 2, 0));
      @(posedge clock);
      @(posedge clock);
      #1;
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'd11;
      req_wdata = 8'hC3;
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check_output("bp_rsp_valid", 32'(rsp_valid), 32'd1);
         check_output("bp_rsp_rdata", 32'(rsp_rdata), 32'h5A);
         check_output("bp_req_ready", 32'(req_ready), 32'd0);
         check_output("bp_en_write", 32'(rf_en_write), 32'd0);
         check_output("bp_address", 32'(rf_address), 32'd10);
      end
      req_valid = 1'b0;
      @(posedge clock);
      #1;
      rsp_ready = 1'b1;
      wait_drain();
      check_output("bp_wr_pulses", 32'(en_pulses - pulses_before), 32'd0);

      // Reset in the middle of a write: the write is lost, bus released at once.
      apply_stimulus(mk(1'b1, 8'd20, 8'h33, 8'h00, 1'b0, 1, 0));
      wait_drain();
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 8'd20;
      req_wdata = 8'hEE;
      exp_bus_addr = 8'd20;
      exp_bus_data = 8'hEE;
      @(negedge clock);
      check_output("rst_wr_accept", 32'(req_ready), 32'd1);
      @(posedge clock);
      #1;
      req_valid = 1'b0;
      check_output("rst_wr_en_before", 32'(rf_en_write), 32'd1);
      #2;
      reset_n  = 1'b0;
      model_oe = 1'b0;
      #1;
      sb.delete();
      resp_seen = 1'b0;
      check_output("rst_mid_en_write", 32'(rf_en_write), 32'd0);
      check_output("rst_mid_bus", 32'(rf_data), 32'hFF);
      check_output("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
      check_output("rst_mid_req_ready", 32'(req_ready), 32'd0);
      @(posedge clock);
      @(posedge clock);
      #1;
      reset_n  = 1'b1;
      model_oe = 1'b1;
      #1;
      check_output("rst_release_ready", 32'(req_ready), 32'd1);
      apply_stimulus(mk(1'b0, 8'd20, 8'h00, 8'h33, 1'b0, 2, 0));
      wait_drain();
      repeat (3) @(posedge clock);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
